rr_pkt_mux: RTL and testbench
=============================

# rr_pkt_mux

Packet-level ingress stage that sits around the round-robin arbiter. It presents per-port valid traffic as the arbiter's request vector and consumes the arbiter's one-hot grant. It then locks onto the granted port for a whole packet and forwards that packet's beats through a registered valid/ready output until `last` is transferred. Packets from different ports are never interleaved.

## Interface
- `NUM_PORTS`, 4: number of ingress ports; must be ≥ 2.
- `DATA_W`, 32: beat payload width.
- `MAX_BEATS`, 16: beat limit per packet; used only under `RR_PKT_MUX_MAXLEN_EN`; must be ≥ 1.

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  NUM_PORTS  per-port beat valid.
- `in_data_i`  in  NUM_PORTS*DATA_W  per-port payload; port k is bits [k*DATA_W +: DATA_W].
- `in_last_i`  in  NUM_PORTS  per-port end-of-packet marker.
- `in_ready_o`  out  NUM_PORTS  per-port beat accept.
- `req_o`  out  NUM_PORTS  request vector driven to the arbiter's `req_i`.
- `gnt_i`  in  NUM_PORTS  grant vector taken from the arbiter's `gnt_o`.
- `out_valid_o`  out  1  output beat valid (registered).
- `out_data_o`  out  DATA_W  output payload (registered).
- `out_last_o`  out  1  output end-of-packet (registered).
- `out_ready_i`  in  1  downstream accept.
- `owner_o`  out  $clog2(NUM_PORTS)  index of the locked port; meaningful only while `busy_o` = 1.
- `busy_o`  out  1  high while in LOCKED.
- `err_o`  out  1  sticky flag for an illegal grant; clears only on reset.
- `trunc_o`  out  1  one-cycle pulse when a packet is force-terminated. Tied to 0 without the macro.

## Operation
- FSM states: IDLE and LOCKED.
- **IDLE:**
  - `req_o = in_valid_i`.
  - `in_ready_o` = 0.
  - If `gnt_i` is one-hot and the granted port has `in_valid_i` = 1: capture its index into `owner_o` and go to LOCKED.
  - If `gnt_i` is zero, or its single bit is on a port without valid: stay in IDLE with no side effects.
  - If `gnt_i` has more than one bit set: set `err_o`, stay in IDLE, capture nothing.
- **LOCKED:**
  - `req_o` = 0.
  - `in_ready_o[owner]` = output-register-free, where free = `!out_valid_o || out_ready_i`. All other `in_ready_o` bits are 0.
  - `gnt_i` is ignored.
  - A beat transfers when `in_valid_i[owner] && in_ready_o[owner]`. It loads `out_data_o`/`out_last_o` and sets `out_valid_o`.
  - A transfer with `in_last_i[owner]` = 1 returns the FSM to IDLE.
- **Output register:**
  - A transfer loads it.
  - `out_ready_i` with no new transfer clears `out_valid_o`.
  - `out_data_o`/`out_last_o` hold while `out_valid_o && !out_ready_i`.
- **Reset (asynchronous, mid-packet included):**
  - State goes to IDLE.
  - `out_valid_o`, `out_last_o`, `out_data_o`, `owner_o`, `busy_o`, `err_o`, `trunc_o` all go to 0.
  - Any partially forwarded packet is abandoned; nothing is replayed.

## Timing
- `req_o`, `in_ready_o` are combinational from state, `in_valid_i`, `out_valid_o`, `out_ready_i`. There is no combinational path from `gnt_i` to any output.
- Grant accepted in cycle N:
  - `busy_o` = 1 from N+1.
  - First beat can transfer in N+1.
  - First beat appears on `out_valid_o` at N+2.
- Throughput in LOCKED: 1 beat/cycle while `out_ready_i` is held high.
- Packet gap: a last beat transferring in cycle M gives IDLE and `req_o` reasserted at M+1. The next grant can be taken at M+1, so there is a minimum 1-cycle input bubble between packets.
- A single-beat packet (`last` on the first beat) occupies LOCKED for exactly one cycle when the output register is free.
- Back-pressure: `out_ready_i` = 0 with `out_valid_o` = 1 drops `in_ready_o[owner]` in the same cycle.

## Configuration
- **`RR_PKT_MUX_MAXLEN_EN` defined:**
  - A beat counter of width $clog2(MAX_BEATS+1) is cleared on entering LOCKED and increments per transfer.
  - On the transfer that brings the count to `MAX_BEATS` with `in_last_i` = 0, the block does all of the following:
    - forces `out_last_o` = 1 on that beat;
    - returns to IDLE;
    - pulses `trunc_o` in the following cycle.
  - The remaining beats of that packet are handled as a new packet at the next grant.
- **`RR_PKT_MUX_MAXLEN_EN` undefined:**
  - No counter; `trunc_o` = 0.
  - LOCKED is held until `last`, with no upper bound.

## Test plan
- Reset, then port 2 valid with a 3-beat packet, `gnt_i`=4'b0100, `out_ready_i`=1:
  - `busy_o` rises the next cycle with `owner_o`=2.
  - Three beats come out on consecutive cycles, the third with `out_last_o`=1.
  - `req_o` returns to 4'b0100 or 0 one cycle after the last transfer.
- Ports 0 and 3 both valid; port 0 granted mid-packet while `gnt_i` changes to 4'b1000:
  - No port-3 beat appears until port 0's `last` is transferred.
  - `req_o` stays 0 during LOCKED.
- `out_ready_i` held 0 for 5 cycles mid-packet:
  - `out_data_o` stays stable.
  - `in_ready_o[owner]` = 0 throughout.
  - No beat is lost or duplicated after release.
- `gnt_i`=4'b0011 in IDLE:
  - `err_o`=1 and stays 1.
  - State stays IDLE.
  - A following legal grant 4'b0001 is still serviced normally.
- `reset` asserted low on the 2nd beat of a 4-beat packet:
  - All outputs go to 0 immediately.
  - After release, `req_o` mirrors `in_valid_i`.
- With `RR_PKT_MUX_MAXLEN_EN` and `MAX_BEATS`=4, a 6-beat packet:
  - Beat 4 is output with `out_last_o`=1.
  - `trunc_o` pulses once.
  - Beats 5–6 form a new packet after re-grant.

Source files
------------

// File: rtl/rr_pkt_mux_if.sv
// rr_pkt_mux_if: ingress, arbiter, egress and status signals of rr_pkt_mux
interface rr_pkt_mux_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);
  localparam int OW = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0]        in_valid_i;
  logic [NUM_PORTS*DATA_W-1:0] in_data_i;
  logic [NUM_PORTS-1:0]        in_last_i;
  logic [NUM_PORTS-1:0]        in_ready_o;
  logic [NUM_PORTS-1:0]        req_o;
  logic [NUM_PORTS-1:0]        gnt_i;
  logic                        out_valid_o;
  logic [DATA_W-1:0]           out_data_o;
  logic                        out_last_o;
  logic                        out_ready_i;
  logic [OW-1:0]               owner_o;
  logic                        busy_o;
  logic                        err_o;
  logic                        trunc_o;
  modport master (
    output in_valid_i, in_data_i, in_last_i, gnt_i, out_ready_i,
    input  in_ready_o, req_o, out_valid_o, out_data_o, out_last_o, owner_o, busy_o, err_o, trunc_o
  );
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, gnt_i, out_ready_i,
    output in_ready_o, req_o, out_valid_o, out_data_o, out_last_o, owner_o, busy_o, err_o, trunc_o
  );
endinterface

// File: rtl/rr_pkt_mux.sv
// rr_pkt_mux: packet-locking ingress mux around a round-robin arbiter; RR_PKT_MUX_MAXLEN_EN enables MAX_BEATS truncation
module rr_pkt_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input logic         clk,
  input logic         reset,
  rr_pkt_mux_if.slave bus
);
  localparam int OW = $clog2(NUM_PORTS);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  if (NUM_PORTS < 2 || MAX_BEATS < 1) begin : g_bad_param
    $error("rr_pkt_mux: NUM_PORTS must be >= 2 and MAX_BEATS >= 1");
  end
  logic [0:0]        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d, gnt_idx;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              locked, free, gnt_one, gnt_multi, take, xfer, last_in, eff_last;
  assign locked    = state_q == LOCKED;
  assign free      = !out_valid_q || bus.out_ready_i;
  assign gnt_one   = bus.gnt_i != '0 && (bus.gnt_i & (bus.gnt_i - NUM_PORTS'(1))) == '0;
  assign gnt_multi = !locked && bus.gnt_i != '0 && !gnt_one;
  assign take      = !locked && gnt_one && |(bus.gnt_i & bus.in_valid_i);
  assign xfer      = locked && free && bus.in_valid_i[owner_q];
  assign last_in   = bus.in_last_i[owner_q];
  assign bus.req_o       = locked ? '0 : bus.in_valid_i;
  assign bus.in_ready_o  = locked && free ? NUM_PORTS'(1) << owner_q : '0;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = locked;
  assign bus.err_o       = err_q;
`ifdef RR_PKT_MUX_MAXLEN_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trunc_q, trunc_d, hit;
  assign hit          = cnt_q == CW'(MAX_BEATS - 1) && !last_in;
  assign eff_last     = last_in || hit;
  assign bus.trunc_o  = trunc_q;
  // beat counter restarts on each grant; the MAX_BEATS-th beat without last is forced to end the packet
  always_comb begin
    cnt_d   = take ? '0 : xfer ? cnt_q + CW'(1) : cnt_q;
    trunc_d = xfer && hit;
  end
  // counter and one-cycle truncation pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
`else
  assign eff_last    = last_in;
  assign bus.trunc_o = 1'b0;
`endif
  // encode the grant bit; only used when the grant is one-hot
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (bus.gnt_i[i]) gnt_idx = OW'(i);
  end
  // lock on a valid one-hot grant, release after the packet's final beat, load the output register per transfer
  always_comb begin
    state_d     = take ? LOCKED : xfer && eff_last ? IDLE : state_q;
    owner_d     = take ? gnt_idx : owner_q;
    err_d       = err_q || gnt_multi;
    out_valid_d = xfer || (out_valid_q && !bus.out_ready_i);
    out_data_d  = xfer ? bus.in_data_i[owner_q*DATA_W +: DATA_W] : out_data_q;
    out_last_d  = xfer ? eff_last : out_last_q;
  end
  // state, owner, sticky error and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_rr_pkt_mux.sv
// tb_rr_pkt_mux: scoreboard bench for rr_pkt_mux
module tb_rr_pkt_mux;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int trunc_cnt = 0;
  logic [DW:0] exp_q[$];
  rr_pkt_mux_if #(.NUM_PORTS(NP), .DATA_W(DW)) b ();
  rr_pkt_mux #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BEATS(MB)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(input int p, input int k);
    return DW'(32'hA500_0000 | (p << 8) | k);
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int p, input int k, input logic last);
    b.in_valid_i[p]          = 1'b1;
    b.in_data_i[p*DW +: DW]  = dval(p, k);
    b.in_last_i[p]           = last;
  endtask

  task automatic drive_pkt(input int p, input int n, input logic [NP-1:0] gl);
    int t;
    logic xl;
    b.gnt_i = NP'(1) << p;
    for (int k = 0; k < n; k++) begin
      t  = 0;
      xl = k == n - 1;
`ifdef RR_PKT_MUX_MAXLEN_EN
      xl = xl || (k % MB == MB - 1);
`endif
      set_beat(p, k, k == n - 1);
      do begin
        @(negedge clk);
        t++;
      end while (!b.in_ready_o[p] && t < 20);
      chk("in_ready_onehot", 64'(b.in_ready_o), 64'(NP'(1) << p));
      chk("req_locked", 64'(b.req_o), 64'(0));
      exp_q.push_back({xl, dval(p, k)});
      tick();
      b.gnt_i = gl;
    end
    b.in_valid_i[p] = 1'b0;
    b.in_last_i[p]  = 1'b0;
  endtask

  task automatic monitor();
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (b.trunc_o) trunc_cnt++;
      if (reset && b.out_valid_o && b.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_beat: got %0h, want no beat", {b.out_last_o, b.out_data_o});
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({b.out_last_o, b.out_data_o}), 64'(e));
        end
      end
    end
  endtask

  initial begin
    b.in_valid_i  = '0;
    b.in_data_i   = '0;
    b.in_last_i   = '0;
    b.gnt_i       = '0;
    b.out_ready_i = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(b.out_valid_o), 64'(0));
    chk("rst_busy", 64'(b.busy_o), 64'(0));
    chk("rst_err", 64'(b.err_o), 64'(0));
    chk("rst_trunc", 64'(b.trunc_o), 64'(0));
    tick();
    reset = 1'b1;
    // basic 3-beat packet on port 2
    set_beat(2, 0, 1'b0);
    b.gnt_i = 4'b0100;
    @(negedge clk);
    chk("t1_req_idle", 64'(b.req_o), 64'(4'b0100));
    chk("t1_ready_idle", 64'(b.in_ready_o), 64'(0));
    chk("t1_busy_idle", 64'(b.busy_o), 64'(0));
    tick();
    b.gnt_i = '0;
    @(negedge clk);
    chk("t1_busy", 64'(b.busy_o), 64'(1));
    chk("t1_owner", 64'(b.owner_o), 64'(2));
    chk("t1_req_locked", 64'(b.req_o), 64'(0));
    chk("t1_ready0", 64'(b.in_ready_o), 64'(4'b0100));
    chk("t1_outv_n1", 64'(b.out_valid_o), 64'(0));
    exp_q.push_back({1'b0, dval(2, 0)});
    tick();
    set_beat(2, 1, 1'b0);
    @(negedge clk);
    chk("t1_ready1", 64'(b.in_ready_o), 64'(4'b0100));
    chk("t1_outv_n2", 64'(b.out_valid_o), 64'(1));
    exp_q.push_back({1'b0, dval(2, 1)});
    tick();
    set_beat(2, 2, 1'b1);
    @(negedge clk);
    chk("t1_ready2", 64'(b.in_ready_o), 64'(4'b0100));
    exp_q.push_back({1'b1, dval(2, 2)});
    tick();
    b.in_valid_i[2] = 1'b0;
    b.in_last_i[2]  = 1'b0;
    @(negedge clk);
    chk("t1_busy_after", 64'(b.busy_o), 64'(0));
    chk("t1_req_after", 64'(b.req_o), 64'(0));
    chk("t1_last_out", 64'(b.out_last_o), 64'(1));
    tick();
    // port 0 locked while port 3 waits and the grant moves to port 3
    set_beat(3, 0, 1'b1);
    drive_pkt(0, 3, 4'b1000);
    @(negedge clk);
    chk("t2_req_gap", 64'(b.req_o), 64'(4'b1000));
    chk("t2_busy_gap", 64'(b.busy_o), 64'(0));
    drive_pkt(3, 1, '0);
    // back-pressure for 5 cycles mid-packet on port 1
    fork
      drive_pkt(1, 4, '0);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(b.out_valid_o && b.busy_o) && t < 20);
        tick();
        b.out_ready_i = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_data", 64'(b.out_data_o), 64'(exp_q.size() != 0 ? exp_q[0][DW-1:0] : '1));
          chk("t3_hold_ready", 64'(b.in_ready_o), 64'(0));
          chk("t3_hold_valid", 64'(b.out_valid_o), 64'(1));
        end
        tick();
        b.out_ready_i = 1'b1;
      end
    join
    // multi-bit grant sets the sticky error, then a legal grant works
    set_beat(0, 0, 1'b0);
    set_beat(1, 0, 1'b0);
    b.gnt_i = 4'b0011;
    @(negedge clk);
    chk("t4_req", 64'(b.req_o), 64'(4'b0011));
    tick();
    b.gnt_i = '0;
    @(negedge clk);
    chk("t4_err", 64'(b.err_o), 64'(1));
    chk("t4_busy", 64'(b.busy_o), 64'(0));
    chk("t4_ready", 64'(b.in_ready_o), 64'(0));
    drive_pkt(0, 2, '0);
    b.in_valid_i[1] = 1'b0;
    @(negedge clk);
    chk("t4_err_sticky", 64'(b.err_o), 64'(1));
    tick();
    // asynchronous reset on the 2nd beat of a 4-beat packet
    set_beat(2, 0, 1'b0);
    b.gnt_i = 4'b0100;
    tick();
    b.gnt_i = '0;
    @(negedge clk);
    chk("t5_ready", 64'(b.in_ready_o), 64'(4'b0100));
    tick();
    set_beat(2, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t5_outv", 64'(b.out_valid_o), 64'(0));
    chk("t5_data", 64'(b.out_data_o), 64'(0));
    chk("t5_last", 64'(b.out_last_o), 64'(0));
    chk("t5_owner", 64'(b.owner_o), 64'(0));
    chk("t5_busy", 64'(b.busy_o), 64'(0));
    chk("t5_err", 64'(b.err_o), 64'(0));
    chk("t5_trunc", 64'(b.trunc_o), 64'(0));
    chk("t5_ready", 64'(b.in_ready_o), 64'(0));
    chk("t5_req_rst", 64'(b.req_o), 64'(4'b0100));
    exp_q.delete();
    b.in_valid_i = 4'b1010;
    b.in_last_i  = '0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_req_rel", 64'(b.req_o), 64'(4'b1010));
    chk("t5_busy_rel", 64'(b.busy_o), 64'(0));
    chk("t5_outv_rel", 64'(b.out_valid_o), 64'(0));
    tick();
    b.in_valid_i = '0;
    // 6-beat packet: truncated after MB beats when the limit is built in
    drive_pkt(1, 6, 4'b0010);
    b.gnt_i = '0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'(0));
`ifdef RR_PKT_MUX_MAXLEN_EN
    chk("trunc_pulses", 64'(trunc_cnt), 64'(1));
`else
    chk("trunc_pulses", 64'(trunc_cnt), 64'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
